// File: rtl/pattern_sequencer_pkg.sv
// pattern_sequencer_pkg: FSM state encoding and width helper shared by the sequencer files.
package pattern_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  function automatic int width(input int x);
    return (x > 2) ? $clog2(x) : 1;
  endfunction
endpackage

// File: rtl/osf_divider.sv
// osf_divider: oversampling phase counter cascaded into a sample index counter.
module osf_divider
  import pattern_sequencer_pkg::*;
#(
  parameter int SAMPLES = 128,
  parameter int OSF = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Clr,
  input  logic                        En,
  output logic [width(OSF)-1:0]       Phase,
  output logic [width(SAMPLES)-1:0]   Sample_Idx,
  output logic                        Last
);
  localparam int PW = width(OSF);
  localparam int IW = width(SAMPLES);
  logic wrap;
  assign wrap = Phase == PW'(OSF - 1);
  assign Last = wrap && Sample_Idx == IW'(SAMPLES - 1);
  always_ff @(posedge Clk) begin
    if (Reset || Clr) begin
      Phase <= '0;
      Sample_Idx <= '0;
    end else if (En) begin
      Phase <= wrap ? '0 : Phase + 1'b1;
      if (wrap) Sample_Idx <= Last ? '0 : Sample_Idx + 1'b1;
    end
  end
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: capture FSM driving an external sample counter with oversampled phase tracking.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int SAMPLES = 128,
  parameter int OSF = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        Abort,
  input  logic                        Hold,
  input  logic                        Term,
  output logic                        Cnt_Clr,
  output logic                        Cnt_En,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Sample_Strobe,
  output logic [width(SAMPLES)-1:0]   Sample_Idx,
  output logic [width(OSF)-1:0]       Phase,
  output logic                        Err
);
  localparam int PW = width(OSF);
  state_t state;
  logic last;
  // Reset masks the strobes combinationally so they are quiet in the reset cycle itself.
  assign Cnt_Clr = !Reset && state == CLEAR;
  assign Busy = !Reset && (state == CLEAR || state == RUN);
  assign Done = !Reset && state == DONE;
  assign Cnt_En = !Reset && state == RUN && !Hold && !Abort;
  assign Sample_Strobe = Cnt_En && Phase == PW'(OSF - 1);
  osf_divider #(.SAMPLES(SAMPLES), .OSF(OSF)) u_div (
    .Clk(Clk),
    .Reset(Reset),
    .Clr(state == CLEAR && !Abort),
    .En(Cnt_En),
    .Phase(Phase),
    .Sample_Idx(Sample_Idx),
    .Last(last)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      Err <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= Start ? CLEAR : IDLE;
        CLEAR: begin
          state <= Abort ? IDLE : RUN;
          Err <= 1'b0;
        end
        RUN: begin
          state <= Abort ? IDLE : (Cnt_En && last) ? DONE : RUN;
          if (Cnt_En && Term) Err <= 1'b1;
        end
        default: begin
          state <= IDLE;
          if (!Term) Err <= 1'b1;
        end
      endcase
    end
  end
endmodule
